// File: rtl/input_fifo_buffer.sv
// Multi-lane first-word-fall-through input FIFO between the external data port and the compute array.
// Define INBUF_OVF_EN to add the sticky OVF_ERR flag for writes dropped while full.
module input_fifo_buffer #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 4
) (
    input  logic                         CLKEXT,
    input  logic                         CLR_BUF_IN,
    input  logic                         FLUSH,
    input  logic                         EN_BUF_IN,
    input  logic [NUM_CH*DATA_W-1:0]     D_IN,
    output logic                         IN_READY,
    input  logic                         RD_EN,
    output logic [NUM_CH*DATA_W-1:0]     Q_OUT,
    output logic                         OUT_VALID,
    output logic                         FULL,
    output logic                         EMPTY,
    output logic [$clog2(DEPTH):0]       COUNT
`ifdef INBUF_OVF_EN
    ,
    output logic                         OVF_ERR
`endif
);

    localparam int VEC_W = NUM_CH * DATA_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [VEC_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic full_q;
    logic empty_q;
    logic wr_acc;
    logic rd_acc;
    logic wr_go;
    logic rd_go;

    // Flags come only from the registered count, so they never glitch on input changes.
    assign full_q    = (count_q == FULL_CNT);
    assign empty_q   = (count_q == '0);
    assign FULL      = full_q;
    assign EMPTY     = empty_q;
    assign IN_READY  = ~full_q;
    assign OUT_VALID = ~empty_q;
    assign COUNT     = count_q;

    assign wr_acc = EN_BUF_IN & ~full_q;
    assign rd_acc = RD_EN & ~empty_q;
    assign wr_go  = wr_acc & ~FLUSH;
    assign rd_go  = rd_acc & ~FLUSH;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (wr_go) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_go) rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({wr_go, rd_go})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLKEXT or negedge CLR_BUF_IN) begin
        if (!CLR_BUF_IN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is reset deliberately so Q_OUT reads 0 after reset; this makes it flops, not RAM.
    always_ff @(posedge CLKEXT or negedge CLR_BUF_IN) begin
        if (!CLR_BUF_IN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_go) begin
            mem[wr_ptr_q] <= D_IN;
        end
    end

    // Fall-through head: stale data while empty, qualified downstream by OUT_VALID.
    assign Q_OUT = mem[rd_ptr_q];

`ifdef INBUF_OVF_EN
    logic ovf_q;

    always_ff @(posedge CLKEXT or negedge CLR_BUF_IN) begin
        if (!CLR_BUF_IN) begin
            ovf_q <= 1'b0;
        end else if (FLUSH) begin
            ovf_q <= 1'b0;
        end else if (EN_BUF_IN && full_q) begin
            ovf_q <= 1'b1;
        end
    end

    assign OVF_ERR = ovf_q;
`endif

endmodule

// File: tb/tb_input_fifo_buffer.sv
// Directed self-checking bench for input_fifo_buffer (default 4 lanes x 8 bits, depth 4).
module tb_input_fifo_buffer;

    logic        CLKEXT;
    logic        CLR_BUF_IN;
    logic        FLUSH;
    logic        EN_BUF_IN;
    logic [31:0] D_IN;
    logic        IN_READY;
    logic        RD_EN;
    logic [31:0] Q_OUT;
    logic        OUT_VALID;
    logic        FULL;
    logic        EMPTY;
    logic [2:0]  COUNT;
`ifdef INBUF_OVF_EN
    logic        OVF_ERR;
`endif

    int total = 0;
    int bad   = 0;

    input_fifo_buffer #(.DATA_W(8), .NUM_CH(4), .DEPTH(4)) dut (
        .CLKEXT    (CLKEXT),
        .CLR_BUF_IN(CLR_BUF_IN),
        .FLUSH     (FLUSH),
        .EN_BUF_IN (EN_BUF_IN),
        .D_IN      (D_IN),
        .IN_READY  (IN_READY),
        .RD_EN     (RD_EN),
        .Q_OUT     (Q_OUT),
        .OUT_VALID (OUT_VALID),
        .FULL      (FULL),
        .EMPTY     (EMPTY),
        .COUNT     (COUNT)
`ifdef INBUF_OVF_EN
        ,
        .OVF_ERR   (OVF_ERR)
`endif
    );

    initial CLKEXT = 1'b0;
    always #5 CLKEXT = ~CLKEXT;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic cyc(input logic en, input logic [31:0] d, input logic rd, input logic fl);
        EN_BUF_IN = en;
        D_IN      = d;
        RD_EN     = rd;
        FLUSH     = fl;
        @(posedge CLKEXT);
        #1;
        EN_BUF_IN = 1'b0;
        RD_EN     = 1'b0;
        FLUSH     = 1'b0;
    endtask

    function automatic logic [31:0] rep(input logic [7:0] b);
        return {b, b, b, b};
    endfunction

    initial begin
        CLR_BUF_IN = 1'b0;
        FLUSH      = 1'b0;
        EN_BUF_IN  = 1'b0;
        RD_EN      = 1'b0;
        D_IN       = '0;
        #3;
        check("rst_q",      Q_OUT,     32'h0);
        check("rst_count",  COUNT,     0);
        check("rst_empty",  EMPTY,     1);
        check("rst_full",   FULL,      0);
        check("rst_ready",  IN_READY,  1);
        check("rst_valid",  OUT_VALID, 0);
`ifdef INBUF_OVF_EN
        check("rst_ovf",    OVF_ERR,   0);
`endif
        #9 CLR_BUF_IN = 1'b1;

        // Single write then read
        cyc(1, 32'h44332211, 0, 0);
        check("w1_valid", OUT_VALID, 1);
        check("w1_q",     Q_OUT,     32'h44332211);
        check("w1_count", COUNT,     1);
        cyc(0, 0, 1, 0);
        check("r1_empty", EMPTY, 1);
        check("r1_count", COUNT, 0);

        // Fill to full, overflow write dropped
        for (int i = 1; i <= 4; i++) cyc(1, rep(8'(i)), 0, 0);
        check("fill_full",  FULL,     1);
        check("fill_ready", IN_READY, 0);
        check("fill_count", COUNT,    4);
        cyc(1, rep(8'h05), 0, 0);
        check("ovf_count", COUNT, 4);
        check("ovf_head",  Q_OUT, rep(8'h01));
`ifdef INBUF_OVF_EN
        check("ovf_flag",  OVF_ERR, 1);
`endif
        for (int i = 1; i <= 4; i++) begin
            check("drain_q", Q_OUT, rep(8'(i)));
            cyc(0, 0, 1, 0);
        end
        check("drain_empty", EMPTY, 1);

        // Streaming at COUNT=2 across pointer wrap
        cyc(1, 32'd100, 0, 0);
        cyc(1, 32'd101, 0, 0);
        for (int i = 0; i < 10; i++) begin
            check("stream_q", Q_OUT, 32'(100 + i));
            cyc(1, 32'(102 + i), 1, 0);
            check("stream_count", COUNT, 2);
        end
        check("stream_tail0", Q_OUT, 32'd110);
        cyc(0, 0, 1, 0);
        check("stream_tail1", Q_OUT, 32'd111);
        cyc(0, 0, 1, 0);
        check("stream_empty", EMPTY, 1);

        // Simultaneous write+read at EMPTY and at FULL
        cyc(1, rep(8'hE0), 1, 0);
        check("we_count", COUNT, 1);
        check("we_q",     Q_OUT, rep(8'hE0));
        cyc(1, rep(8'hE1), 0, 0);
        cyc(1, rep(8'hE2), 0, 0);
        cyc(1, rep(8'hE3), 0, 0);
        check("wf_full",  COUNT, 4);
        cyc(1, rep(8'hF0), 1, 0);
        check("wf_count", COUNT, 3);
        for (int i = 1; i <= 3; i++) begin
            check("wf_drain", Q_OUT, rep(8'(8'hE0 + i)));
            cyc(0, 0, 1, 0);
        end
        check("wf_empty", EMPTY, 1);

        // FLUSH with concurrent write at COUNT=3
        cyc(1, 32'h30, 0, 0);
        cyc(1, 32'h31, 0, 0);
        cyc(1, 32'h32, 0, 0);
        check("fl_pre", COUNT, 3);
        cyc(1, 32'h33, 0, 1);
        check("fl_count", COUNT,     0);
        check("fl_empty", EMPTY,     1);
        check("fl_valid", OUT_VALID, 0);
`ifdef INBUF_OVF_EN
        check("fl_ovf",   OVF_ERR,   0);
`endif
        cyc(1, 32'h50, 0, 0);
        check("fl_next_q",     Q_OUT, 32'h50);
        check("fl_next_count", COUNT, 1);
        cyc(0, 0, 1, 0);
        check("fl_next_empty", EMPTY, 1);

        // Asynchronous reset mid-cycle at COUNT=3
        cyc(1, 32'h60, 0, 0);
        cyc(1, 32'h61, 0, 0);
        cyc(1, 32'h62, 0, 0);
        check("ar_pre", COUNT, 3);
        #2 CLR_BUF_IN = 1'b0;
        #1;
        check("ar_q",     Q_OUT,    32'h0);
        check("ar_count", COUNT,    0);
        check("ar_ready", IN_READY, 1);
        check("ar_empty", EMPTY,    1);
        #2 CLR_BUF_IN = 1'b1;
        cyc(1, 32'hAABBCCDD, 0, 0);
        check("ar_wr_q",     Q_OUT, 32'hAABBCCDD);
        check("ar_wr_count", COUNT, 1);
        cyc(0, 0, 1, 0);
        check("ar_rd_empty", EMPTY, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
